// File: rtl/pic_row_streamer_if.sv
// Bundle between the LCD timing driver / picture ROM side and the row streamer.
// data_req is a request with no backpressure; pixel_valid qualifies pixel_data exactly one cycle later.
interface pic_row_streamer_if #(
    parameter int ADDR_W = 9,
    parameter int PIX_W  = 16,
    parameter int PIC_W  = 200
);
    logic                     frame_start;
    logic                     line_start;
    logic [10:0]              line_y;
    logic                     data_req;
    logic [10:0]              pixel_xpos;
    logic [ADDR_W-1:0]        rom_addr;
    logic [PIC_W*PIX_W-1:0]   rom_q;
    logic [PIX_W-1:0]         pixel_data;
    logic                     pixel_valid;
    logic                     busy;
    logic                     late_err;
    logic [2:0]               dbg_state;

    modport slave (
        input  frame_start, line_start, line_y, data_req, pixel_xpos, rom_q,
        output rom_addr, pixel_data, pixel_valid, busy, late_err, dbg_state
    );

    modport master (
        output frame_start, line_start, line_y, data_req, pixel_xpos, rom_q,
        input  rom_addr, pixel_data, pixel_valid, busy, late_err, dbg_state
    );
endinterface

// File: rtl/pic_row_streamer.sv
// Fetches one picture ROM row per LCD line and serializes it MSB-first into pixels
// inside the picture window; background colour everywhere else.
module pic_row_streamer #(
    parameter int              ADDR_W   = 9,
    parameter int              PIX_W    = 16,
    parameter int              PIC_W    = 200,
    parameter int              PIC_H    = 10,
    parameter int              X_START  = 100,
    parameter int              Y_START  = 50,
    parameter logic [PIX_W-1:0] BG_COLOR = 16'hFFFF
) (
    input  logic               lcd_clk,
    input  logic               rst_n,
    pic_row_streamer_if.slave  bus
);
    localparam int ROW_W = PIC_W * PIX_W;
    localparam int CNT_W = $clog2(PIC_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PIC_W - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] ARMED = 3'd3;
    localparam logic [2:0] SHIFT = 3'd4;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ROW_W-1:0]  row_buf;
    logic [ADDR_W-1:0] rom_addr_r;
    logic [PIX_W-1:0]  pix_r;
    logic              pv_r;
    logic              late_r;

    logic hit;
    logic in_win;

    assign hit    = bus.data_req && (bus.pixel_xpos == 11'(X_START));
    assign in_win = (bus.line_y >= 11'(Y_START)) && (bus.line_y < 11'(Y_START + PIC_H));

    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            row_buf    <= '0;
            rom_addr_r <= '0;
            pix_r      <= '0;
            pv_r       <= 1'b0;
            late_r     <= 1'b0;
        end else begin
            pix_r <= BG_COLOR;
            pv_r  <= 1'b0;
            // A late error later in this block overrides the frame_start clear.
            if (bus.frame_start) late_r <= 1'b0;

            if (bus.line_start) begin
                cnt <= '0;
                if (in_win) begin
                    state      <= FETCH;
                    rom_addr_r <= ADDR_W'(bus.line_y - 11'(Y_START));
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (hit) begin
                            late_r <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            state <= LATCH;
                        end
                    end
                    LATCH: begin
                        row_buf <= bus.rom_q;
                        if (hit) begin
                            late_r <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (hit) begin
                            pix_r   <= row_buf[ROW_W-1 -: PIX_W];
                            pv_r    <= 1'b1;
                            row_buf <= row_buf << PIX_W;
                            cnt     <= CNT_W'(1);
                            state   <= (PIC_W == 1) ? IDLE : SHIFT;
                        end
                    end
                    SHIFT: begin
                        // The buffer shifts left so the next pixel is always at the top.
                        if (bus.data_req) begin
                            pix_r   <= row_buf[ROW_W-1 -: PIX_W];
                            pv_r    <= 1'b1;
                            row_buf <= row_buf << PIX_W;
                            if (cnt == LAST) begin
                                cnt   <= '0;
                                state <= IDLE;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rom_addr    = rom_addr_r;
    assign bus.pixel_data  = pix_r;
    assign bus.pixel_valid = pv_r;
    assign bus.late_err    = late_r;
    assign bus.busy        = (state != IDLE);
    assign bus.dbg_state   = state;
endmodule
